// File: rtl/act_window_loader_pkg.sv
// Shared types, sizes and configuration helpers for the activation window loader
// and its downstream select stage.
package act_window_loader_pkg;

    localparam int unsigned RAM_ROW    = 33;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned PE_MAC     = 14;
    localparam int unsigned WIN_W      = 16;
    localparam int unsigned LEN_W      = 6;
    localparam int unsigned K_W        = 3;
    localparam int unsigned S_W        = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2,
        NEXT    = 2'd3
    } state_t;

    typedef struct packed {
        logic [K_W-1:0]   kernel_size;
        logic [S_W-1:0]   stride;
        logic [WIN_W-1:0] num_windows;
    } cfg_t;

    // Number of stream words (rows) that make up one window.
    function automatic logic [LEN_W-1:0] load_len(input logic [K_W-1:0] k,
                                                  input logic [S_W-1:0] s);
        if (s == S_W'(1)) begin
            return LEN_W'(2 * PE_MAC - 1) + LEN_W'(k);
        end
        return LEN_W'((PE_MAC - 1) * 2) + LEN_W'(k);
    endfunction

    // Odd kernels only, stride 1 or 2, window must fit the row register, at least one window.
    function automatic logic cfg_legal(input logic [K_W-1:0]   k,
                                       input logic [S_W-1:0]   s,
                                       input logic [WIN_W-1:0] n);
        logic k_ok;
        logic s_ok;
        logic len_ok;
        k_ok   = k[0];
        s_ok   = (s == S_W'(1)) || (s == S_W'(2));
        len_ok = load_len(k, s) <= LEN_W'(RAM_ROW);
        return k_ok && s_ok && len_ok && (n != '0);
    endfunction

endpackage

// File: rtl/act_window_loader.sv
// Gathers activation windows from a word stream into a row register and presents
// them, with tready/reset group timing, to the mask/select stage.
module act_window_loader
    import act_window_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_start,
    input  logic [K_W-1:0]                cfg_kernel_size,
    input  logic [S_W-1:0]                cfg_stride,
    input  logic [WIN_W-1:0]              cfg_num_windows,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DATA_WIDTH*RAM_ROW-1:0] din,
    output logic                          tready,
    output logic                          reset,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
);

    state_t state_q;
    state_t state_d;

    cfg_t             cfg_q;
    cfg_t             cfg_d;
    cfg_t             cfg_in;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic [LEN_W-1:0] word_cnt_q;
    logic [LEN_W-1:0] word_cnt_d;
    logic [K_W-1:0]   hold_cnt_q;
    logic [K_W-1:0]   hold_cnt_d;
    logic             grp_q;
    logic             grp_d;
    logic [WIN_W-1:0] win_cnt_q;
    logic [WIN_W-1:0] win_cnt_d;

    logic s_ready_q;
    logic s_ready_d;
    logic tready_q;
    logic tready_d;
    logic reset_q;
    logic reset_d;
    logic busy_q;
    logic busy_d;
    logic done_q;
    logic done_d;
    logic cfg_err_q;
    logic cfg_err_d;

    logic [DATA_WIDTH-1:0] rows_q [RAM_ROW];

    logic accept;
    logic last_word;
    logic last_hold;
    logic two_groups;
    logic last_win;
    logic load_entry;

    always_comb begin
        cfg_in             = '0;
        cfg_in.kernel_size = cfg_kernel_size;
        cfg_in.stride      = cfg_stride;
        cfg_in.num_windows = cfg_num_windows;
    end

    assign accept     = s_valid && s_ready_q && (state_q == LOAD);
    assign last_word  = (word_cnt_q == (len_q - LEN_W'(1)));
    assign last_hold  = (hold_cnt_q == cfg_q.kernel_size);
    assign two_groups = (cfg_q.stride == S_W'(1));
    assign last_win   = ((win_cnt_q + WIN_W'(1)) == cfg_q.num_windows);
    assign load_entry = (state_d == LOAD) && (state_q != LOAD);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counters and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        hold_cnt_d = hold_cnt_q;
        grp_d      = grp_q;
        win_cnt_d  = win_cnt_q;
        cfg_err_d  = cfg_err_q;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_legal(cfg_kernel_size, cfg_stride, cfg_num_windows)) begin
                        state_d    = LOAD;
                        cfg_d      = cfg_in;
                        len_d      = load_len(cfg_kernel_size, cfg_stride);
                        word_cnt_d = '0;
                        win_cnt_d  = '0;
                        cfg_err_d  = 1'b0;
                    end else begin
                        cfg_err_d  = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    word_cnt_d = word_cnt_q + LEN_W'(1);
                    if (last_word) begin
                        state_d    = PRESENT;
                        hold_cnt_d = K_W'(1);
                        grp_d      = 1'b0;
                    end
                end
            end
            PRESENT: begin
                if (last_hold) begin
                    // Stride 1 replays the window as a second group for the other half select.
                    if (two_groups && !grp_q) begin
                        grp_d      = 1'b1;
                        hold_cnt_d = K_W'(1);
                    end else begin
                        state_d    = NEXT;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + K_W'(1);
                end
            end
            NEXT: begin
                win_cnt_d = win_cnt_q + WIN_W'(1);
                if (last_win) begin
                    state_d    = IDLE;
                end else begin
                    state_d    = LOAD;
                    word_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        s_ready_d = (state_d == LOAD);
        tready_d  = (state_d == PRESENT);
        reset_d   = tready_d && two_groups && (hold_cnt_d == cfg_q.kernel_size);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == NEXT) && last_win;
    end

    // Configuration, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q      <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            hold_cnt_q <= '0;
            grp_q      <= 1'b0;
            win_cnt_q  <= '0;
            s_ready_q  <= 1'b0;
            tready_q   <= 1'b0;
            reset_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_q      <= cfg_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            grp_q      <= grp_d;
            win_cnt_q  <= win_cnt_d;
            s_ready_q  <= s_ready_d;
            tready_q   <= tready_d;
            reset_q    <= reset_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Window rows: tail rows beyond the window length are zeroed on every load entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RAM_ROW); i++) begin
                rows_q[i] <= '0;
            end
        end else if (load_entry) begin
            for (int i = 0; i < int'(RAM_ROW); i++) begin
                if (LEN_W'(i) >= len_d) begin
                    rows_q[i] <= '0;
                end
            end
        end else if (accept) begin
            rows_q[word_cnt_q] <= s_data;
        end
    end

    for (genvar g = 0; g < int'(RAM_ROW); g++) begin : g_din
        assign din[g*DATA_WIDTH +: DATA_WIDTH] = rows_q[g];
    end

    assign s_ready = s_ready_q;
    assign tready  = tready_q;
    assign reset   = reset_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_act_window_loader.sv
// Scoreboard bench for act_window_loader: a driver streams random windows and queues
// expected beats; a negedge monitor pops and compares every beat and directed check.
module tb_act_window_loader;
    import act_window_loader_pkg::*;

    localparam int unsigned BUS_W = DATA_WIDTH * RAM_ROW;

    localparam logic [5:0] F_SRDY = 6'b100000;
    localparam logic [5:0] F_TRDY = 6'b010000;
    localparam logic [5:0] F_RST  = 6'b001000;
    localparam logic [5:0] F_BUSY = 6'b000100;
    localparam logic [5:0] F_DONE = 6'b000010;
    localparam logic [5:0] F_ERR  = 6'b000001;
    localparam logic [5:0] F_ALL  = 6'b111111;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cfg_start = 1'b0;
    logic [K_W-1:0]        cfg_kernel_size = '0;
    logic [S_W-1:0]        cfg_stride = '0;
    logic [WIN_W-1:0]      cfg_num_windows = '0;
    logic [DATA_WIDTH-1:0] s_data = '0;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [BUS_W-1:0]      din;
    logic                  tready;
    logic                  reset;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;

    act_window_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_start       (cfg_start),
        .cfg_kernel_size (cfg_kernel_size),
        .cfg_stride      (cfg_stride),
        .cfg_num_windows (cfg_num_windows),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .din             (din),
        .tready          (tready),
        .reset           (reset),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BUS_W-1:0] din;
        logic             rst;
        logic             last;
    } beat_t;

    typedef struct {
        int         cyc;
        int         kind;
        logic [5:0] mask;
        logic [5:0] exp;
        logic       din_zero;
        string      name;
    } dchk_t;

    beat_t q[$];
    dchk_t dq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    jobs_done = 0;
    bit    exp_done = 0;

    // Monitor: every beat, done pulse and queued directed check is compared here.
    always @(negedge clk) begin : monitor
        beat_t      b;
        dchk_t      d;
        int         bad;
        logic [5:0] flags;
        cyc = cyc + 1;
        flags = {s_ready, tready, reset, busy, done, cfg_err};
        if (!rst_n) begin
            exp_done = 0;
        end else begin
            checks++;
            if (exp_done) begin
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL done_pulse: cycle %0d got done=%b expected 1", cyc, done);
                end
                exp_done = 0;
                jobs_done++;
            end else if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_spurious: cycle %0d got done=%b expected 0", cyc, done);
            end
            checks++;
            if (reset && !tready) begin
                errors++;
                $display("FAIL reset_without_beat: cycle %0d got reset=1 expected 0", cyc);
            end
            if (tready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: cycle %0d got tready=1 expected 0", cyc);
                end else begin
                    b = q.pop_front();
                    bad = -1;
                    for (int i = int'(RAM_ROW) - 1; i >= 0; i--) begin
                        if (din[i*DATA_WIDTH +: DATA_WIDTH] !== b.din[i*DATA_WIDTH +: DATA_WIDTH]) bad = i;
                    end
                    if (bad >= 0 || reset !== b.rst || busy !== 1'b1) begin
                        errors++;
                        if (bad < 0) bad = 0;
                        $display("FAIL beat: cycle %0d row %0d got %h expected %h, reset got %b expected %b, busy got %b expected 1",
                                 cyc, bad, din[bad*DATA_WIDTH +: DATA_WIDTH], b.din[bad*DATA_WIDTH +: DATA_WIDTH],
                                 reset, b.rst, busy);
                    end
                    if (b.last) exp_done = 1;
                end
            end
        end
        while (dq.size() > 0 && dq[0].cyc <= cyc) begin
            d = dq.pop_front();
            checks++;
            if (d.kind != 0) begin
                errors++;
                $display("FAIL %s: cycle %0d wait bound expired, expected DUT progress", d.name, cyc);
            end else if (((flags & d.mask) !== (d.exp & d.mask)) || (d.din_zero && din !== '0)) begin
                errors++;
                $display("FAIL %s: cycle %0d got flags %b din_zero %b, expected flags %b (mask %b) din_zero %b",
                         d.name, cyc, flags & d.mask, din == '0, d.exp & d.mask, d.mask, d.din_zero);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue a check of output flags for the coming negedge (called just after a posedge).
    task automatic expect_flags(input string name, input logic [5:0] mask, input logic [5:0] exp,
                                input logic dz, input int kind);
        dchk_t d;
        d.cyc = cyc + 1;
        d.kind = kind;
        d.mask = mask;
        d.exp = exp;
        d.din_zero = dz;
        d.name = name;
        dq.push_back(d);
    endtask

    // One job: model expected beats, start it, stream words per mode, await done.
    // mode 0 = full rate, 1 = valid toggling 1/0, 2 = random gaps.
    task automatic run_job(input int k, input int s, input int n, input int mode,
                           input bit seq, input bit poke);
        int                    ll;
        int                    g;
        int                    idx;
        int                    budget;
        int                    start_jobs;
        bit                    tog;
        bit                    poked;
        bit                    acc;
        logic [DATA_WIDTH-1:0] words[$];
        logic [BUS_W-1:0]      flat;
        beat_t                 b;
        ll = (s == 1) ? (2 * int'(PE_MAC) - 1 + k) : ((int'(PE_MAC) - 1) * 2 + k);
        g  = (s == 1) ? 2 : 1;
        for (int w = 0; w < n; w++) begin
            for (int i = 0; i < ll; i++) begin
                words.push_back(seq ? DATA_WIDTH'(w * ll + i + 1) : {$urandom, $urandom});
            end
        end
        for (int w = 0; w < n; w++) begin
            flat = '0;
            for (int i = 0; i < ll; i++) flat[i*DATA_WIDTH +: DATA_WIDTH] = words[w*ll + i];
            for (int bt = 1; bt <= g * k; bt++) begin
                b.din  = flat;
                b.rst  = (s == 1) && (bt % k == 0);
                b.last = (w == n - 1) && (bt == g * k);
                q.push_back(b);
            end
        end

        start_jobs = jobs_done;
        cfg_kernel_size = K_W'(k);
        cfg_stride = S_W'(s);
        cfg_num_windows = WIN_W'(n);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_kernel_size = K_W'($urandom);
        cfg_stride = S_W'($urandom);
        cfg_num_windows = WIN_W'($urandom);
        expect_flags("start", F_SRDY | F_TRDY | F_BUSY | F_ERR, F_SRDY | F_BUSY, 1'b0, 0);

        poked = 0;
        tog = 1;
        for (int w = 0; w < n; w++) begin
            idx = 0;
            budget = 0;
            while (idx < ll && budget < 400) begin
                cfg_start = 1'b0;
                if (poke && !poked && tready) begin
                    cfg_start = 1'b1;
                    cfg_kernel_size = K_W'(1);
                    cfg_stride = S_W'(2);
                    cfg_num_windows = WIN_W'(1);
                    poked = 1;
                end
                case (mode)
                    0: s_valid = 1'b1;
                    1: begin s_valid = tog; tog = !tog; end
                    default: s_valid = ($urandom_range(3) != 0);
                endcase
                s_data = s_valid ? words[w*ll + idx] : {$urandom, $urandom};
                acc = s_valid && s_ready;
                tick();
                budget++;
                if (acc) idx++;
            end
            cfg_start = 1'b0;
            if (idx < ll) begin
                expect_flags("load_timeout", F_ALL, '0, 1'b0, 1);
            end else begin
                expect_flags("latency", F_SRDY | F_TRDY | F_BUSY, F_TRDY | F_BUSY, 1'b0, 0);
            end
        end
        s_valid = 1'b0;

        budget = 0;
        while (jobs_done == start_jobs && budget < 200) begin
            tick();
            budget++;
        end
        if (jobs_done == start_jobs) begin
            expect_flags("done_timeout", F_ALL, '0, 1'b0, 1);
            q.delete();
            tick();
        end else begin
            expect_flags("idle_after", F_SRDY | F_TRDY | F_BUSY | F_DONE, '0, 1'b0, 0);
        end
        tick();
    endtask

    task automatic illegal(input int k, input int s, input int n);
        cfg_kernel_size = K_W'(k);
        cfg_stride = S_W'(s);
        cfg_num_windows = WIN_W'(n);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        expect_flags("illegal", F_ERR | F_BUSY | F_SRDY | F_TRDY, F_ERR, 1'b0, 0);
        repeat (3) tick();
        expect_flags("illegal_hold", F_ERR | F_BUSY | F_SRDY | F_TRDY, F_ERR, 1'b0, 0);
        tick();
    endtask

    initial begin : driver
        int rk;
        int rs;
        int rn;
        repeat (2) @(posedge clk);
        #1;
        expect_flags("reset_vals", F_ALL, '0, 1'b1, 0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_flags("post_reset", F_ALL, '0, 1'b1, 0);
        tick();

        run_job(3, 2, 1, 0, 1, 0);
        run_job(3, 1, 1, 0, 0, 0);
        run_job(7, 2, 2, 1, 0, 0);

        illegal(7, 1, 1);
        illegal(3, 3, 4);
        illegal(2, 2, 1);
        illegal(5, 1, 0);
        run_job(1, 2, 1, 2, 0, 0);

        // Abort a load after 10 words with an asynchronous reset.
        cfg_kernel_size = K_W'(3);
        cfg_stride = S_W'(2);
        cfg_num_windows = WIN_W'(1);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        repeat (10) begin
            s_valid = 1'b1;
            s_data = {$urandom, $urandom};
            tick();
        end
        s_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        expect_flags("rst_async", F_ALL, '0, 1'b1, 0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_flags("rst_idle", F_ALL, '0, 1'b1, 0);
        tick();
        run_job(3, 2, 1, 0, 1, 0);

        run_job(5, 1, 2, 2, 0, 1);

        for (int r = 0; r < 4; r++) begin
            rs = int'($urandom_range(2, 1));
            rk = 2 * int'($urandom_range(3, 0)) + 1;
            if (rs == 1 && rk == 7) rk = 5;
            rn = int'($urandom_range(3, 1));
            run_job(rk, rs, rn, int'($urandom_range(2, 0)), 0, 0);
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
